phy_rx_framer: RTL and testbench

// - Downstream of the byte demux: consumes its 8-bit symbol stream (data/K-codes) at clk_250k.
// - Classifies K-codes, strips COM/SKP/IDL fill, extracts STP..END (TLP) and SDP..END (DLLP) frames.
// - Emits each payload byte with start/end markers, and flags framing errors, for the link layer.

---
 rtl/phy_rx_framer_pkg.sv | 43 ++++
 rtl/phy_rx_framer_if.sv | 27 ++
 rtl/phy_rx_hold_reg.sv | 31 +++
 rtl/phy_rx_framer.sv | 168 ++++++++++++++++
 tb/tb_phy_rx_framer.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/phy_rx_framer_pkg.sv
// Shared symbol definitions for the receive framer: K-code values, FSM states
// and the symbol classifier used by the framing logic.
package phy_rx_framer_pkg;

  localparam logic [7:0] K_COM = 8'hbc;
  localparam logic [7:0] K_SKP = 8'h1c;
  localparam logic [7:0] K_STP = 8'hfb;
  localparam logic [7:0] K_SDP = 8'h5c;
  localparam logic [7:0] K_END = 8'hfd;
  localparam logic [7:0] K_IDL = 8'h7c;

  typedef enum logic [1:0] {
    S_IDLE,
    S_TLP,
    S_DLLP
  } state_e;

  typedef enum logic [2:0] {
    SYM_DATA,
    SYM_COM,
    SYM_SKP,
    SYM_STP,
    SYM_SDP,
    SYM_END,
    SYM_IDL
  } sym_e;

  // Anything that is not one of the six recognised K-codes is payload.
  function automatic sym_e classify(input logic [7:0] b);
    sym_e s;
    case (b)
      K_COM:   s = SYM_COM;
      K_SKP:   s = SYM_SKP;
      K_STP:   s = SYM_STP;
      K_SDP:   s = SYM_SDP;
      K_END:   s = SYM_END;
      K_IDL:   s = SYM_IDL;
      default: s = SYM_DATA;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/phy_rx_framer_if.sv
// Symbol input and framed-packet output bundle of the receive framer.
interface phy_rx_framer_if;
  logic       valid_in;
  logic [7:0] data_in;
  logic       pkt_valid;
  logic [7:0] pkt_data;
  logic       pkt_sop;
  logic       pkt_eop;
  logic       pkt_type;
  logic       pkt_abort;
  logic [7:0] control;
  logic       err;
  logic [7:0] skp_count;
  logic       link_idle;

  modport master (
    output valid_in, data_in,
    input  pkt_valid, pkt_data, pkt_sop, pkt_eop, pkt_type, pkt_abort,
    input  control, err, skp_count, link_idle
  );

  modport slave (
    input  valid_in, data_in,
    output pkt_valid, pkt_data, pkt_sop, pkt_eop, pkt_type, pkt_abort,
    output control, err, skp_count, link_idle
  );
endinterface

// File: rtl/phy_rx_hold_reg.sv
// One-entry byte buffer that delays payload by one symbol so the byte before
// END can be tagged as end-of-packet.
module phy_rx_hold_reg (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic       flush_i,
  input  logic [7:0] data_i,
  output logic       full_o,
  output logic [7:0] data_o
);

  logic       full_q;
  logic [7:0] data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (load_i) begin
      full_q <= 1'b1;
      data_q <= data_i;
    end else if (flush_i) begin
      full_q <= 1'b0;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/phy_rx_framer.sv
// Receive framer: classifies symbols, strips fill, extracts STP/SDP..END frames
// and emits payload bytes with sop/eop/abort markers plus link status.
module phy_rx_framer
  import phy_rx_framer_pkg::*;
#(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned LEN_W   = 5
) (
  input logic            clk_250k,
  input logic            reset_L,
  phy_rx_framer_if.slave rx
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             first_q, first_d;
  logic             type_q, type_d;
  logic [7:0]       skp_q, skp_d;
  logic [2:0]       run_q, run_d;

  logic             pv_q, sop_q, eop_q, abort_q, err_q, idle_q;
  logic [7:0]       pd_q, ctl_q;

  logic             emit, emit_eop, abort_d, err_d, open_frame;
  logic [7:0]       ctl_d;
  logic             hold_load, hold_flush, hold_full;
  logic [7:0]       hold_data;
  sym_e             sym;

  phy_rx_hold_reg u_hold (
    .clk_i   (clk_250k),
    .rst_ni  (reset_L),
    .load_i  (hold_load),
    .flush_i (hold_flush),
    .data_i  (rx.data_in),
    .full_o  (hold_full),
    .data_o  (hold_data)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    first_d    = first_q;
    type_d     = type_q;
    skp_d      = skp_q;
    run_d      = run_q;
    hold_load  = 1'b0;
    hold_flush = 1'b0;
    emit       = 1'b0;
    emit_eop   = 1'b0;
    abort_d    = 1'b0;
    err_d      = 1'b0;
    open_frame = 1'b0;
    ctl_d      = '0;
    sym        = classify(rx.data_in);

    if (rx.valid_in) begin
      ctl_d = (sym == SYM_DATA) ? 8'h00 : rx.data_in;

      if (sym == SYM_SKP && skp_q != 8'hff) skp_d = skp_q + 8'd1;

      if (sym == SYM_IDL) begin
        if (run_q != 3'd7) run_d = run_q + 3'd1;
      end else begin
        run_d = '0;
      end

      case (state_q)
        S_IDLE: begin
          case (sym)
            SYM_STP, SYM_SDP:  open_frame = 1'b1;
            SYM_DATA, SYM_END: err_d      = 1'b1;
            default: ;
          endcase
        end
        default: begin
          case (sym)
            SYM_DATA: begin
              // The overflowing byte and the still-held byte are both dropped.
              if (len_q == LEN_W'(MAX_LEN)) begin
                err_d      = 1'b1;
                abort_d    = ~first_q;
                hold_flush = 1'b1;
                state_d    = S_IDLE;
              end else begin
                len_d     = len_q + LEN_W'(1);
                hold_load = 1'b1;
                emit      = hold_full;
              end
            end
            SYM_END: begin
              if (len_q != '0) begin
                emit       = 1'b1;
                emit_eop   = 1'b1;
                hold_flush = 1'b1;
              end else begin
                err_d = 1'b1;
              end
              state_d = S_IDLE;
            end
            default: begin
              err_d      = 1'b1;
              abort_d    = ~first_q;
              hold_flush = 1'b1;
              state_d    = S_IDLE;
              open_frame = (sym == SYM_STP) || (sym == SYM_SDP);
            end
          endcase
        end
      endcase

      if (emit) first_d = 1'b0;

      if (open_frame) begin
        state_d = (sym == SYM_SDP) ? S_DLLP : S_TLP;
        len_d   = '0;
        first_d = 1'b1;
        type_d  = (sym == SYM_SDP);
      end
    end
  end

  always_ff @(posedge clk_250k or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      first_q <= 1'b0;
      type_q  <= 1'b0;
      skp_q   <= '0;
      run_q   <= '0;
      pv_q    <= 1'b0;
      pd_q    <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
      ctl_q   <= '0;
      idle_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      first_q <= first_d;
      type_q  <= type_d;
      skp_q   <= skp_d;
      run_q   <= run_d;
      pv_q    <= emit;
      sop_q   <= emit & first_q;
      eop_q   <= emit_eop;
      abort_q <= abort_d;
      err_q   <= err_d;
      ctl_q   <= ctl_d;
      idle_q  <= (run_d >= 3'd4);
      if (emit) pd_q <= hold_data;
    end
  end

  assign rx.pkt_valid = pv_q;
  assign rx.pkt_data  = pd_q;
  assign rx.pkt_sop   = sop_q;
  assign rx.pkt_eop   = eop_q;
  assign rx.pkt_type  = type_q;
  assign rx.pkt_abort = abort_q;
  assign rx.control   = ctl_q;
  assign rx.err       = err_q;
  assign rx.skp_count = skp_q;
  assign rx.link_idle = idle_q;

endmodule

// File: tb/tb_phy_rx_framer.sv
// Directed bench for phy_rx_framer: default build plus a MAX_LEN=4 build fed
// the same symbol stream; sel picks which instance the checks observe.
module tb_phy_rx_framer;

  logic clk = 1'b0;
  logic reset_L;
  logic sel = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  phy_rx_framer_if bus16 ();
  phy_rx_framer_if bus4 ();

  phy_rx_framer #(.MAX_LEN(16), .LEN_W(5)) dut (
    .clk_250k (clk),
    .reset_L  (reset_L),
    .rx       (bus16)
  );

  phy_rx_framer #(.MAX_LEN(4), .LEN_W(3)) dut4 (
    .clk_250k (clk),
    .reset_L  (reset_L),
    .rx       (bus4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic sym(input logic v, input logic [7:0] d, input logic [7:0] ectl,
                     input logic eerr, input logic eabt, input logic epv,
                     input logic [7:0] epd, input logic esop, input logic eeop,
                     input logic ety);
    @(negedge clk);
    bus16.valid_in = v;  bus16.data_in = d;
    bus4.valid_in  = v;  bus4.data_in  = d;
    @(posedge clk);
    #1;
    chk("control", sel ? bus4.control   : bus16.control,   ectl);
    chk("err",     sel ? bus4.err       : bus16.err,       eerr);
    chk("abort",   sel ? bus4.pkt_abort : bus16.pkt_abort, eabt);
    chk("pvalid",  sel ? bus4.pkt_valid : bus16.pkt_valid, epv);
    if (epv) begin
      chk("pdata", sel ? bus4.pkt_data : bus16.pkt_data, epd);
      chk("sop",   sel ? bus4.pkt_sop  : bus16.pkt_sop,  esop);
      chk("eop",   sel ? bus4.pkt_eop  : bus16.pkt_eop,  eeop);
      chk("ptype", sel ? bus4.pkt_type : bus16.pkt_type, ety);
    end
  endtask

  task automatic q(input logic [7:0] d, input logic [7:0] ectl, input logic eerr, input logic eabt);
    sym(1'b1, d, ectl, eerr, eabt, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic e(input logic [7:0] d, input logic [7:0] ectl, input logic [7:0] epd,
                   input logic esop, input logic eeop, input logic ety);
    sym(1'b1, d, ectl, 1'b0, 1'b0, 1'b1, epd, esop, eeop, ety);
  endtask

  task automatic gap();
    sym(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_reset_state();
    chk("rst_pvalid", bus16.pkt_valid, 1'b0);
    chk("rst_sop",    bus16.pkt_sop,   1'b0);
    chk("rst_eop",    bus16.pkt_eop,   1'b0);
    chk("rst_type",   bus16.pkt_type,  1'b0);
    chk("rst_abort",  bus16.pkt_abort, 1'b0);
    chk("rst_ctl",    bus16.control,   8'h00);
    chk("rst_err",    bus16.err,       1'b0);
    chk("rst_skp",    bus16.skp_count, 8'h00);
    chk("rst_idle",   bus16.link_idle, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_L = 1'b0;
    bus16.valid_in = 1'b0;  bus16.data_in = 8'h00;
    bus4.valid_in  = 1'b0;  bus4.data_in  = 8'h00;
    #12;
    chk_reset_state();
    @(negedge clk);
    reset_L = 1'b1;

    // COMx4 then a two-byte TLP
    repeat (4) q(8'hbc, 8'hbc, 1'b0, 1'b0);
    q(8'hfb, 8'hfb, 1'b0, 1'b0);
    q(8'h01, 8'h00, 1'b0, 1'b0);
    e(8'h02, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0);
    e(8'hfd, 8'hfd, 8'h02, 1'b0, 1'b1, 1'b0);
    gap();

    // SKPx12 then a ten-byte TLP
    repeat (12) q(8'h1c, 8'h1c, 1'b0, 1'b0);
    chk("skp12", bus16.skp_count, 8'd12);
    q(8'hfb, 8'hfb, 1'b0, 1'b0);
    for (int i = 3; i <= 12; i++) begin
      if (i == 3) q(8'(i), 8'h00, 1'b0, 1'b0);
      else        e(8'(i), 8'h00, 8'(i - 1), i == 4, 1'b0, 1'b0);
    end
    e(8'hfd, 8'hfd, 8'h0c, 1'b0, 1'b1, 1'b0);

    // DLLP then IDL run
    q(8'h5c, 8'h5c, 1'b0, 1'b0);
    q(8'h0d, 8'h00, 1'b0, 1'b0);
    e(8'h0e, 8'h00, 8'h0d, 1'b1, 1'b0, 1'b1);
    e(8'hfd, 8'hfd, 8'h0e, 1'b0, 1'b1, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      q(8'h7c, 8'h7c, 1'b0, 1'b0);
      chk("link_idle", bus16.link_idle, i == 4);
    end
    gap();
    chk("idle_hold", bus16.link_idle, 1'b1);

    // Empty frame, END and data outside a frame
    q(8'hfb, 8'hfb, 1'b0, 1'b0);
    chk("idle_clr", bus16.link_idle, 1'b0);
    q(8'hfd, 8'hfd, 1'b1, 1'b0);
    q(8'hfd, 8'hfd, 1'b1, 1'b0);
    q(8'haa, 8'h00, 1'b1, 1'b0);

    // In-frame K-codes: abort after sop, silent kill before sop, 1-byte DLLP
    q(8'hfb, 8'hfb, 1'b0, 1'b0);
    q(8'h11, 8'h00, 1'b0, 1'b0);
    e(8'h22, 8'h00, 8'h11, 1'b1, 1'b0, 1'b0);
    q(8'h1c, 8'h1c, 1'b1, 1'b1);
    chk("skp13", bus16.skp_count, 8'd13);
    q(8'h33, 8'h00, 1'b1, 1'b0);
    q(8'hfb, 8'hfb, 1'b0, 1'b0);
    q(8'h44, 8'h00, 1'b0, 1'b0);
    q(8'h5c, 8'h5c, 1'b1, 1'b0);
    q(8'h55, 8'h00, 1'b0, 1'b0);
    e(8'hfd, 8'hfd, 8'h55, 1'b1, 1'b1, 1'b1);

    // Overflow on the MAX_LEN=4 instance
    sel = 1'b1;
    q(8'hfb, 8'hfb, 1'b0, 1'b0);
    q(8'h01, 8'h00, 1'b0, 1'b0);
    e(8'h02, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0);
    e(8'h03, 8'h00, 8'h02, 1'b0, 1'b0, 1'b0);
    e(8'h04, 8'h00, 8'h03, 1'b0, 1'b0, 1'b0);
    q(8'h05, 8'h00, 1'b1, 1'b1);
    q(8'h06, 8'h00, 1'b1, 1'b0);
    q(8'hfd, 8'hfd, 1'b1, 1'b0);
    sel = 1'b0;

    // valid_in gaps inside a frame
    q(8'hfb, 8'hfb, 1'b0, 1'b0);
    q(8'h01, 8'h00, 1'b0, 1'b0);
    repeat (3) gap();
    e(8'h02, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0);
    e(8'hfd, 8'hfd, 8'h02, 1'b0, 1'b1, 1'b0);

    // Reset mid-frame drops the frame without abort
    q(8'hfb, 8'hfb, 1'b0, 1'b0);
    q(8'h01, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    #2 reset_L = 1'b0;
    #1;
    chk_reset_state();
    @(negedge clk);
    reset_L = 1'b1;
    q(8'h02, 8'h00, 1'b1, 1'b0);
    q(8'hfd, 8'hfd, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
